// File: rtl/ber_disp_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : ber_disp_sched_if
//  Purpose  : Handshake bundle between the channel scheduler and the shared
//             BER display engine (start pulse, count snapshots, busy).
//  Revision : 1.0  initial release
// ============================================================================
interface ber_disp_sched_if;
   logic        ENG_START;
   logic [59:0] ENG_RECV_CNT;
   logic [63:0] ENG_ERR_CNT;
   logic        ENG_BUSY;

   // Scheduler side: issues work, observes busy
   modport master (
      output ENG_START,
      output ENG_RECV_CNT,
      output ENG_ERR_CNT,
      input  ENG_BUSY
   );

   // Engine side: accepts work, reports busy
   modport slave (
      input  ENG_START,
      input  ENG_RECV_CNT,
      input  ENG_ERR_CNT,
      output ENG_BUSY
   );
endinterface
`default_nettype wire

// File: rtl/ber_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ber_disp_sched
//  Purpose  : Round-robin scheduler sharing one BER display engine among four
//             channels. Each round snapshots a channel's counters, launches the
//             engine, waits for the result (with a watchdog) and keeps it on
//             the display for DWELL cycles.
//  Options  : BER_SCHED_HOLD_EN - adds input HOLD that freezes the dwell timer.
//  Revision : 1.0  initial release
// ============================================================================
module ber_disp_sched #(
   parameter logic [31:0] DWELL = 32'd50_000_000,
   parameter logic [15:0] WDOG  = 16'd4095
) (
   input  logic            RSTX,
   input  logic            CLK,
   input  logic            ENABLE,
   input  logic [3:0]      CH_VALID,
   input  logic [239:0]    RECV_CNT_ALL,
   input  logic [255:0]    ERR_CNT_ALL,
`ifdef BER_SCHED_HOLD_EN
   input  logic            HOLD,
`endif
   ber_disp_sched_if.master eng,
   output logic [1:0]      CH_SEL,
   output logic            DISP_VALID,
   output logic            WDOG_ERR
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARB    = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DWELL  = 3'd4
   } state_t;

   state_t      r_state;
   logic        r_eng_start;
   logic [59:0] r_recv_snap;
   logic [63:0] r_err_snap;
   logic [1:0]  r_ch_sel;
   logic        r_disp_valid;
   logic        r_wdog_err;
   logic [31:0] r_dwell_cnt;
   logic [15:0] r_wdog_cnt;

   logic        w_hold;
   logic        w_found;
   logic [1:0]  w_pick;
   logic [1:0]  w_idx;
   logic [59:0] w_recv_sel;
   logic [63:0] w_err_sel;
   logic        w_dwell_last;
   logic        w_wdog_hit;

`ifdef BER_SCHED_HOLD_EN
   assign w_hold = HOLD;
`else
   assign w_hold = 1'b0;
`endif

   assign eng.ENG_START    = r_eng_start;
   assign eng.ENG_RECV_CNT = r_recv_snap;
   assign eng.ENG_ERR_CNT  = r_err_snap;
   assign CH_SEL           = r_ch_sel;
   assign DISP_VALID       = r_disp_valid;
   assign WDOG_ERR         = r_wdog_err;

   // Compare in one extra bit so DWELL/WDOG of zero never underflow.
   assign w_dwell_last = ({1'b0, r_dwell_cnt} + 33'd1) >= {1'b0, DWELL};
   assign w_wdog_hit   = ({1'b0, r_wdog_cnt}  + 17'd1) >= {1'b0, WDOG};

   // Round-robin search from last+1; the last channel is tried last.
   // Scanning downwards lets the nearest candidate overwrite the farther ones.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_ch_sel;
      w_idx   = r_ch_sel;
      for (int k = 4; k >= 1; k--) begin
         w_idx = r_ch_sel + k[1:0];
         if (CH_VALID[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // Counter slices of the candidate channel.
   always_comb begin
      w_recv_sel = RECV_CNT_ALL[59:0];
      w_err_sel  = ERR_CNT_ALL[63:0];
      case (w_pick)
         2'd0: begin w_recv_sel = RECV_CNT_ALL[59:0];    w_err_sel = ERR_CNT_ALL[63:0];    end
         2'd1: begin w_recv_sel = RECV_CNT_ALL[119:60];  w_err_sel = ERR_CNT_ALL[127:64];  end
         2'd2: begin w_recv_sel = RECV_CNT_ALL[179:120]; w_err_sel = ERR_CNT_ALL[191:128]; end
         default: begin w_recv_sel = RECV_CNT_ALL[239:180]; w_err_sel = ERR_CNT_ALL[255:192]; end
      endcase
   end

   // Scheduler state machine with registered outputs.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         r_state      <= ST_IDLE;
         r_eng_start  <= 1'b0;
         r_recv_snap  <= 60'd0;
         r_err_snap   <= 64'd0;
         r_ch_sel     <= 2'd3;
         r_disp_valid <= 1'b0;
         r_wdog_err   <= 1'b0;
         r_dwell_cnt  <= 32'd0;
         r_wdog_cnt   <= 16'd0;
      end else begin
         r_eng_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ENABLE) begin
                  r_state <= ST_ARB;
               end
            end

            // A stuck engine may still be busy after a watchdog expiry, so a
            // new launch also waits for the engine to go idle.
            ST_ARB: begin
               if (!ENABLE) begin
                  r_state <= ST_IDLE;
               end else if (w_found && !eng.ENG_BUSY) begin
                  r_ch_sel     <= w_pick;
                  r_recv_snap  <= w_recv_sel;
                  r_err_snap   <= w_err_sel;
                  r_disp_valid <= 1'b0;
                  r_eng_start  <= 1'b1;
                  r_state      <= ST_LAUNCH;
               end
            end

            ST_LAUNCH: begin
               r_wdog_cnt <= 16'd0;
               r_state    <= ST_WAIT;
            end

            // Engine raises busy in the first wait cycle, so idle here means done.
            ST_WAIT: begin
               if (!eng.ENG_BUSY) begin
                  r_disp_valid <= 1'b1;
                  r_wdog_cnt   <= 16'd0;
                  r_dwell_cnt  <= 32'd0;
                  r_state      <= ST_DWELL;
               end else if (w_wdog_hit) begin
                  r_wdog_err <= 1'b1;
                  r_wdog_cnt <= 16'd0;
                  r_state    <= ST_ARB;
               end else begin
                  r_wdog_cnt <= r_wdog_cnt + 16'd1;
               end
            end

            // HOLD freezes the timer; the display stays valid when stopping.
            ST_DWELL: begin
               if (!w_hold) begin
                  if (w_dwell_last) begin
                     r_dwell_cnt <= 32'd0;
                     r_state     <= ENABLE ? ST_ARB : ST_IDLE;
                  end else begin
                     r_dwell_cnt <= r_dwell_cnt + 32'd1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ber_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ber_disp_sched
//  Purpose  : Self-checking bench for ber_disp_sched with a timeline model of
//             the scheduling rules, an engine model and directed scenarios.
//  Options  : BER_SCHED_HOLD_EN - also exercises the HOLD input.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ber_disp_sched;

   localparam int DW = 10;
   localparam int WD = 100;

   logic         CLK = 1'b0;
   logic         RSTX = 1'b0;
   logic         ENABLE = 1'b0;
   logic [3:0]   CH_VALID = 4'd0;
   logic [239:0] RECV = '0;
   logic [255:0] ERR = '0;
   logic [1:0]   ch_sel;
   logic         disp_valid;
   logic         wdog_err;
`ifdef BER_SCHED_HOLD_EN
   logic         HOLD = 1'b0;
`endif

   ber_disp_sched_if eng ();

   ber_disp_sched #(.DWELL(32'd10), .WDOG(16'd100)) dut (
      .RSTX         (RSTX),
      .CLK          (CLK),
      .ENABLE       (ENABLE),
      .CH_VALID     (CH_VALID),
      .RECV_CNT_ALL (RECV),
      .ERR_CNT_ALL  (ERR),
`ifdef BER_SCHED_HOLD_EN
      .HOLD         (HOLD),
`endif
      .eng          (eng),
      .CH_SEL       (ch_sel),
      .DISP_VALID   (disp_valid),
      .WDOG_ERR     (wdog_err)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int starts_cyc[$];
   int starts_ch[$];
   int wd_rise = -1;
   logic wd_prev = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic hold_now();
`ifdef BER_SCHED_HOLD_EN
      return HOLD;
`else
      return 1'b0;
`endif
   endfunction

   // ---------------- engine model: busy for eng_len cycles after START -------
   int   eng_len  = 20;
   bit   eng_hang = 0;
   int   eng_left = 0;
   bit   eng_pend = 0;
   initial begin
      eng.ENG_BUSY = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (!RSTX) begin
            eng.ENG_BUSY = 1'b0;
            eng_pend = 0;
            eng_left = 0;
         end else begin
            if (eng_pend) begin
               eng_pend = 0;
               eng.ENG_BUSY = 1'b1;
               eng_left = eng_len;
            end else if (eng.ENG_BUSY && !eng_hang) begin
               eng_left--;
               if (eng_left <= 0) eng.ENG_BUSY = 1'b0;
            end
            if (eng.ENG_START) eng_pend = 1;
         end
      end
   end

   // ---------------- timeline model -----------------------------------------
   // Phases: stopped, looking for a channel, engine computing, result shown.
   localparam int PH_OFF = 0, PH_SEARCH = 1, PH_RUN = 2, PH_SHOW = 3;
   int          ph;
   int          t_run_from;   // first cycle in which the engine reports busy
   int          t_show_last;  // last cycle of the display period
   logic        exp_start, exp_dv, exp_wd;
   logic [1:0]  exp_ch;
   logic [59:0] exp_recv;
   logic [63:0] exp_err;

   task automatic model_reset();
      ph = PH_OFF;
      exp_start = 0; exp_dv = 0; exp_wd = 0; exp_ch = 2'd3;
      exp_recv = '0; exp_err = '0;
   endtask

   // Decide the outputs of cycle cyc+1 from the inputs present in cycle cyc.
   task automatic model_step();
      int c;
      int j;
      exp_start = 0;
      case (ph)
         PH_OFF: if (ENABLE) ph = PH_SEARCH;
         PH_SEARCH: begin
            if (!ENABLE) ph = PH_OFF;
            else if (!eng.ENG_BUSY) begin
               c = -1;
               for (int s = 1; s <= 4; s++) begin
                  j = (int'(exp_ch) + s) % 4;
                  if (c < 0 && CH_VALID[j]) c = j;
               end
               if (c >= 0) begin
                  exp_ch    = 2'(c);
                  exp_recv  = RECV[60*c +: 60];
                  exp_err   = ERR[64*c +: 64];
                  exp_dv    = 0;
                  exp_start = 1;
                  t_run_from = cyc + 2;
                  ph = PH_RUN;
               end
            end
         end
         PH_RUN: begin
            if (cyc >= t_run_from) begin
               if (!eng.ENG_BUSY) begin
                  exp_dv = 1;
                  t_show_last = cyc + DW;
                  ph = PH_SHOW;
               end else if (cyc - t_run_from + 1 >= WD) begin
                  exp_wd = 1;
                  ph = PH_SEARCH;
               end
            end
         end
         default: begin
            if (hold_now()) t_show_last++;
            else if (cyc >= t_show_last) ph = ENABLE ? PH_SEARCH : PH_OFF;
         end
      endcase
   endtask

   // ---------------- compare process (every cycle) --------------------------
   initial begin
      model_reset();
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RSTX) model_reset();
         chk("eng_start",  eng.ENG_START, exp_start);
         chk("ch_sel",     ch_sel, exp_ch);
         chk("disp_valid", disp_valid, exp_dv);
         chk("wdog_err",   wdog_err, exp_wd);
         chk("recv_snap",  eng.ENG_RECV_CNT, exp_recv);
         chk("err_snap",   eng.ENG_ERR_CNT, exp_err);
         chk("start_while_busy", eng.ENG_START & eng.ENG_BUSY, 0);
         if (eng.ENG_START === 1'b1) begin
            starts_cyc.push_back(cyc);
            starts_ch.push_back(int'(ch_sel));
         end
         if (wdog_err && !wd_prev) wd_rise = cyc;
         wd_prev = wdog_err;
         if (RSTX) model_step();
      end
   end

   // ---------------- stimulus -----------------------------------------------
   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic wait_starts(input int n, input int budget);
      int t;
      t = 0;
      while (starts_ch.size() < n && t < budget) begin
         run_cycles(1);
         t++;
      end
      chk("start_count_reached", starts_ch.size(), n);
   endtask

   task automatic set_counts(input int seed);
      for (int n = 0; n < 4; n++) begin
         RECV[60*n +: 60] = {28'(seed), 28'(n*7 + 1), 4'(n)};
         ERR[64*n +: 64]  = {32'(seed*3 + n), 32'hE000_0000 | 32'(n)};
      end
   endtask

   task automatic rst_on();
      RSTX = 1'b0;
      #1;
      chk("rst_ch_sel",     ch_sel, 2'd3);
      chk("rst_disp_valid", disp_valid, 1'b0);
      chk("rst_eng_start",  eng.ENG_START, 1'b0);
      chk("rst_wdog_err",   wdog_err, 1'b0);
      chk("rst_recv",       eng.ENG_RECV_CNT, 60'd0);
      run_cycles(2);
   endtask

   task automatic rst_off();
      starts_cyc.delete();
      starts_ch.delete();
      wd_rise = -1;
      RSTX = 1'b1;
   endtask

   initial begin
      run_cycles(3);

      // Four valid channels, 20-cycle engine: round robin 0,1,2,3,0, 33 apart
      set_counts(1);
      CH_VALID = 4'b1111;
      ENABLE   = 1'b1;
      rst_off();
      wait_starts(2, 200);
      set_counts(2);
      wait_starts(5, 200);
      for (int i = 0; i < 5; i++) chk("s1_ch_order", starts_ch[i], i % 4);
      for (int i = 1; i < 5; i++) chk("s1_start_gap", starts_cyc[i] - starts_cyc[i-1], 33);

      // Asynchronous reset in the middle of a computation
      wait_starts(6, 100);
      run_cycles(5);
      rst_on();
      rst_off();
      wait_starts(1, 20);
      chk("post_reset_first_ch", starts_ch[0], 0);

      // Sparse valid mask 0101: only channels 0 and 2 are served
      rst_on();
      set_counts(3);
      CH_VALID = 4'b0101;
      rst_off();
      wait_starts(4, 300);
      for (int i = 0; i < 4; i++) chk("s2_ch_order", starts_ch[i], (i % 2) * 2);

      // Engine hangs: watchdog fires after 100 busy wait cycles
      rst_on();
      CH_VALID = 4'b1111;
      eng_hang = 1;
      rst_off();
      wait_starts(1, 20);
      begin
         int t;
         t = 0;
         while (wd_rise < 0 && t < 300) begin
            run_cycles(1);
            t++;
         end
      end
      chk("wdog_latency", wd_rise - starts_cyc[0], 101);
      chk("wdog_disp_valid", disp_valid, 1'b0);
      eng_hang = 0;
      wait_starts(2, 100);
      chk("wdog_next_ch", starts_ch[1], 1);

      // ENABLE dropped while the engine computes
      rst_on();
      set_counts(4);
      CH_VALID = 4'b0010;
      rst_off();
      wait_starts(1, 20);
      run_cycles(5);
      ENABLE = 1'b0;
      run_cycles(60);
      chk("en_drop_starts", starts_ch.size(), 1);
      chk("en_drop_disp_valid", disp_valid, 1'b1);
      chk("en_drop_ch", ch_sel, 2'd1);
      // Nothing valid: scan waits with the old result still shown
      set_counts(9);
      CH_VALID = 4'b0000;
      ENABLE   = 1'b1;
      run_cycles(30);
      chk("none_valid_starts", starts_ch.size(), 1);
      chk("none_valid_disp", disp_valid, 1'b1);
      // Single channel returns with a fresh snapshot
      CH_VALID = 4'b0010;
      wait_starts(2, 100);
      chk("single_ch_again", starts_ch[1], 1);
      chk("single_ch_fresh_recv", eng.ENG_RECV_CNT[59:32], 28'd9);

`ifdef BER_SCHED_HOLD_EN
      // HOLD freezes the dwell period
      rst_on();
      CH_VALID = 4'b0001;
      rst_off();
      wait_starts(1, 20);
      begin
         int t;
         int fall;
         int gap;
         t = 0;
         while (!disp_valid && t < 60) begin
            run_cycles(1);
            t++;
         end
         run_cycles(2);
         HOLD = 1'b1;
         run_cycles(50);
         chk("hold_no_start", starts_ch.size(), 1);
         chk("hold_ch", ch_sel, 2'd0);
         chk("hold_disp", disp_valid, 1'b1);
         HOLD = 1'b0;
         fall = cyc;
         wait_starts(2, 40);
         gap = starts_cyc[1] - fall;
         chk("hold_release_gap", (gap > 0 && gap <= 12), 1'b1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end, want end of scenarios");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/ber_disp_sched.md
BER_DISP_SCHED -- requirements
Module: ber_disp_sched

Interface
REQ-001 SHALL have parameter DWELL, default 32'd50_000_000, meaning CLK cycles each channel's result stays displayed.
REQ-002 SHALL have parameter WDOG, default 16'd4095, meaning maximum CLK cycles allowed for one engine computation.
REQ-003 SHALL have port RSTX  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port ENABLE  input  1  level; 1 = run round-robin scan.
REQ-006 SHALL have port CH_VALID  input  4  per-channel "counters meaningful" flags.
REQ-007 SHALL have port RECV_CNT_ALL  input  240  received-bit counts; channel n at bits [60n+59:60n].
REQ-008 SHALL have port ERR_CNT_ALL  input  256  error counts; channel n at bits [64n+63:64n].
REQ-009 SHALL have port ENG_START  output  1  one-cycle start pulse to the shared BER display engine.
REQ-010 SHALL have port ENG_RECV_CNT  output  60  registered snapshot of the selected channel's received count.
REQ-011 SHALL have port ENG_ERR_CNT  output  64  registered snapshot of the selected channel's error count.
REQ-012 SHALL have port ENG_BUSY  input  1  engine busy; rises the cycle after ENG_START.
REQ-013 SHALL have port CH_SEL  output  2  channel whose result is on the display.
REQ-014 SHALL have port DISP_VALID  output  1  1 = engine digits correspond to CH_SEL.
REQ-015 SHALL have port WDOG_ERR  output  1  sticky flag; engine exceeded WDOG cycles.

Function
REQ-016 SHALL implement states IDLE, ARB, LAUNCH, WAIT, DWELL in a registered state machine.
REQ-017 IDLE: SHALL go to ARB when ENABLE=1; otherwise stay in IDLE.
REQ-018 ARB: SHALL select the first channel with CH_VALID=1, searching last+1, last+2, ... modulo 4 (last included last); SHALL capture its counts into ENG_RECV_CNT/ENG_ERR_CNT, load CH_SEL, clear DISP_VALID, go to LAUNCH.
REQ-019 ARB with CH_VALID=4'b0000: SHALL stay in ARB with outputs unchanged; with ENABLE=0, SHALL go to IDLE.
REQ-020 LAUNCH: SHALL assert ENG_START for exactly one cycle, then go to WAIT; snapshots SHALL stay stable from LAUNCH until the next ARB.
REQ-021 WAIT: SHALL go to DWELL and set DISP_VALID=1 on the first cycle ENG_BUSY=0; the first WAIT cycle already sees ENG_BUSY=1, so no blanking cycle is needed.
REQ-022 WAIT: SHALL count cycles; when the count reaches WDOG with ENG_BUSY still 1, SHALL set WDOG_ERR, leave DISP_VALID=0, go to ARB.
REQ-023 DWELL: SHALL count 0..DWELL-1, then go to ARB if ENABLE=1, otherwise go to IDLE with DISP_VALID held at 1.
REQ-024 ENABLE deasserted in LAUNCH or WAIT: SHALL finish the computation (no abort, no second START) before honouring it.
REQ-025 SHALL never assert ENG_START outside LAUNCH, nor while ENG_BUSY=1.
REQ-026 Single valid channel: SHALL re-select that channel every round and re-launch with fresh snapshots.
REQ-027 Counters: DWELL counter 32 bits, watchdog counter 16 bits; both cleared on each state entry, no wrap-around.

Reset
REQ-028 On RSTX=0: state IDLE, ENG_START=0, ENG_RECV_CNT=0, ENG_ERR_CNT=0, CH_SEL=2'd3 (so channel 0 is searched first), DISP_VALID=0, WDOG_ERR=0, counters 0.
REQ-029 Reset mid-operation SHALL take effect immediately (asynchronous); release SHALL resume only from IDLE.
REQ-030 WDOG_ERR SHALL clear only on reset.

Configuration
REQ-031 With macro BER_SCHED_HOLD_EN defined: SHALL add input HOLD (1 bit); HOLD=1 in DWELL freezes the dwell counter, keeping the current channel displayed indefinitely.
REQ-032 Without BER_SCHED_HOLD_EN: port HOLD SHALL be absent; behaviour is identical to HOLD=0.

Verification
REQ-033 DWELL=10, CH_VALID=4'b1111, engine model busy 20 cycles -> START pulses for CH_SEL 0,1,2,3,0; pulses 1+1+1+20+10=33 cycles apart.
REQ-034 CH_VALID=4'b0101 -> CH_SEL sequence 0,2,0,2; no START issued for channels 1 or 3.
REQ-035 Engine model holds ENG_BUSY=1 forever, WDOG=100 -> WDOG_ERR=1 at cycle 100 of WAIT, DISP_VALID=0, next channel launched.
REQ-036 ENABLE dropped during WAIT -> no further START; DWELL completes; state reaches IDLE with DISP_VALID=1.
REQ-037 RSTX pulsed low mid-WAIT -> all outputs at reset values in the same cycle; after release, first START is for channel 0.
REQ-038 BER_SCHED_HOLD_EN defined, HOLD=1 during DWELL for 50 cycles, DWELL=10 -> CH_SEL unchanged and no START until 10 cycles after HOLD falls.
